// File: rtl/program_loader.sv
// Boot loader: length-prefixed byte stream -> big-endian 16-bit words into instruction memory.
// Optional trailing 8-bit checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [15:0]       o_imem_din,
    output logic              o_imem_we,
    output logic              o_cpu_reset,
    output logic              o_done,
    output logic              o_error,
    output logic [ADDR_W:0]   o_word_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    // State entered once the last word (or an empty image) has been handled.
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_TAIL = S_CHECK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_len;
    logic [15:0]       r_din;
    logic              r_imem_we;
    logic              r_cpu_reset;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W:0]   r_word_count;

    logic              w_rx_ready;
    logic              w_accept;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_last_word;

    assign w_len_full  = {r_len[15:8], i_rx_data};
    assign w_count_inc = r_word_count + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = (16'(w_count_inc) == r_len);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_sum_next;

    assign w_sum_next = r_sum + i_rx_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sum <= 8'h00;
        end else if (w_accept) begin
            r_sum <= w_sum_next;
        end
    end
`endif

    // Ready depends on the registered state only, never on i_rx_valid.
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_rx_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK:                                  w_rx_ready = 1'b1;
`endif
            default:                                  w_rx_ready = 1'b0;
        endcase
    end

    assign w_accept = i_rx_valid & w_rx_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    w_state_next = S_LEN_HI;
            S_LEN_HI:  if (w_accept) w_state_next = S_LEN_LO;
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_full > MAX_N) begin
                        w_state_next = S_ERR;
                    end else if (w_len_full == 16'd0) begin
                        w_state_next = S_TAIL;
                    end else begin
                        w_state_next = S_DATA_HI;
                    end
                end
            end
            S_DATA_HI: if (w_accept) w_state_next = S_DATA_LO;
            S_DATA_LO: if (w_accept) w_state_next = S_WRITE;
            S_WRITE:   w_state_next = w_last_word ? S_TAIL : S_DATA_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) begin
                    w_state_next = (w_sum_next == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE:    w_state_next = S_DONE;
            S_ERR:     w_state_next = S_ERR;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Status flags are registered from the next state so they change on the
    // same edge that enters DONE/ERR/WRITE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len        <= 16'h0000;
            r_din        <= 16'h0000;
            r_imem_we    <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
        end else begin
            if (w_accept && (r_state == S_LEN_HI)) begin
                r_len[15:8] <= i_rx_data;
            end
            if (w_accept && (r_state == S_LEN_LO)) begin
                r_len[7:0] <= i_rx_data;
            end
            if (w_accept && (r_state == S_DATA_HI)) begin
                r_din[15:8] <= i_rx_data;
            end
            if (w_accept && (r_state == S_DATA_LO)) begin
                r_din[7:0] <= i_rx_data;
            end
            if (r_state == S_WRITE) begin
                r_word_count <= w_count_inc;
            end
            r_imem_we   <= (w_state_next == S_WRITE);
            r_done      <= (w_state_next == S_DONE);
            r_error     <= (w_state_next == S_ERR);
            r_cpu_reset <= (w_state_next != S_DONE);
        end
    end

    assign o_rx_ready   = w_rx_ready;
    assign o_imem_addr  = r_word_count[ADDR_W-1:0];
    assign o_imem_din   = r_din;
    assign o_imem_we    = r_imem_we;
    assign o_cpu_reset  = r_cpu_reset;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; memory writes are checked against a scoreboard queue.
// Works with or without LOADER_CHECKSUM_EN defined.
module tb_program_loader;

    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_din;
    logic              imem_we;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_we     = 0;
    int we0;

    logic [ADDR_W+15:0] exp_q[$];
    logic [ADDR_W+15:0] mon_e;
    logic [15:0]        img [0:4095];

    program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(4096)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_rx_ready   (rx_ready),
        .o_imem_addr  (imem_addr),
        .o_imem_din   (imem_din),
        .o_imem_we    (imem_we),
        .o_cpu_reset  (cpu_reset),
        .o_done       (done),
        .o_error      (error),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            n_we++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL unexpected_we: observed addr 0x%0h data 0x%0h expected no write", imem_addr, imem_din);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                assert ({imem_addr, imem_din} === mon_e) else begin
                    n_errors++;
                    $error("FAIL write: observed 0x%0h expected 0x%0h", {imem_addr, imem_din}, mon_e);
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_rx_ready"},   32'(rx_ready),   0);
        chk({tag, "_imem_addr"},  32'(imem_addr),  0);
        chk({tag, "_imem_din"},   32'(imem_din),   0);
        chk({tag, "_imem_we"},    32'(imem_we),    0);
        chk({tag, "_cpu_reset"},  32'(cpu_reset),  1);
        chk({tag, "_done"},       32'(done),       0);
        chk({tag, "_error"},      32'(error),      0);
        chk({tag, "_word_count"}, 32'(word_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!rx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("rx_ready_for_%02h", b), 32'(rx_ready), 1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_image(input int n);
        logic [7:0]  sum;
        logic [15:0] nf;
        nf  = 16'(n);
        sum = nf[15:8] + nf[7:0];
        send_byte(nf[15:8]);
        send_byte(nf[7:0]);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({i[ADDR_W-1:0], img[i]});
            sum = sum + img[i][15:8] + img[i][7:0];
            send_byte(img[i][15:8]);
            send_byte(img[i][7:0]);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 - sum);
`endif
        $display("load: %0d words sent, byte sum 0x%02h", n, sum);
    endtask

    // Without a checksum byte, done rises on the edge leaving the final WRITE.
    task automatic wait_after_last();
`ifndef LOADER_CHECKSUM_EN
        chk("last_write_we", 32'(imem_we), 1);
        chk("done_before_last_write", 32'(done), 0);
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic drive_ignored(input logic [7:0] b, input int exp_wc, input int exp_nwe);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("terminal_rx_ready", 32'(rx_ready), 0);
        end
        rx_valid = 1'b0;
        chk("terminal_word_count", 32'(word_count), 32'(exp_wc));
        chk("terminal_we_count", 32'(n_we), 32'(exp_nwe));
        $display("ignored byte 0x%02h in terminal state", b);
    endtask

    initial begin
        // Reset and the basic two-word image.
        do_reset();
        img[0] = 16'h1234;
        img[1] = 16'hABCD;
        we0 = n_we;
        send_image(2);
        wait_after_last();
        chk("img2_done",      32'(done),        1);
        chk("img2_cpu_reset", 32'(cpu_reset),   0);
        chk("img2_error",     32'(error),       0);
        chk("img2_rx_ready",  32'(rx_ready),    0);
        chk("img2_wc",        32'(word_count),  2);
        chk("img2_sb_empty",  32'(exp_q.size()), 0);
        chk("img2_we_count",  32'(n_we),        32'(we0 + 2));
        drive_ignored(8'h40, 2, we0 + 2);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: words still land, then ERR.
        do_reset();
        exp_q.push_back({12'd0, 16'h1234});
        exp_q.push_back({12'd1, 16'hABCD});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h41);
        chk("badck_error",     32'(error),     1);
        chk("badck_done",      32'(done),      0);
        chk("badck_cpu_reset", 32'(cpu_reset), 1);
        chk("badck_rx_ready",  32'(rx_ready),  0);
        chk("badck_wc",        32'(word_count), 2);
        chk("badck_sb_empty",  32'(exp_q.size()), 0);
        $display("bad checksum stream sent");
`endif

        // Length 4097 exceeds the limit: ERR right after LEN_LO.
        do_reset();
        we0 = n_we;
        send_byte(8'h10);
        send_byte(8'h01);
        chk("len_error",     32'(error),     1);
        chk("len_done",      32'(done),      0);
        chk("len_cpu_reset", 32'(cpu_reset), 1);
        chk("len_rx_ready",  32'(rx_ready),  0);
        drive_ignored(8'h12, 0, we0);
        $display("oversize length stream sent");

        // Five idle cycles between AB and CD must not change anything.
        do_reset();
        exp_q.push_back({12'd0, 16'h1234});
        exp_q.push_back({12'd1, 16'hABCD});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB);
        repeat (5) begin
            @(negedge clk);
            chk("stall_rx_ready", 32'(rx_ready),  1);
            chk("stall_wc",       32'(word_count), 1);
            chk("stall_we",       32'(imem_we),   0);
            chk("stall_done",     32'(done),      0);
        end
        send_byte(8'hCD);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h40);
`endif
        wait_after_last();
        chk("stall_done_final", 32'(done),       1);
        chk("stall_wc_final",   32'(word_count), 2);
        chk("stall_sb_empty",   32'(exp_q.size()), 0);
        $display("stalled two-word stream sent");

        // Reset after the first word, then a fresh one-word image.
        do_reset();
        exp_q.push_back({12'd0, 16'h1234});
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        @(posedge clk);
        #1;
        chk("midload_wc", 32'(word_count), 1);
        do_reset();
        img[0] = 16'hBEEF;
        send_image(1);
        wait_after_last();
        chk("fresh_done",     32'(done),       1);
        chk("fresh_wc",       32'(word_count), 1);
        chk("fresh_din",      32'(imem_din),   32'h0000BEEF);
        chk("fresh_sb_empty", 32'(exp_q.size()), 0);

        // Empty image.
        do_reset();
        we0 = n_we;
        send_image(0);
        chk("empty_done_now", 32'(done), 1);
        repeat (2) @(posedge clk);
        #1;
        chk("empty_done",      32'(done),      1);
        chk("empty_cpu_reset", 32'(cpu_reset), 0);
        chk("empty_wc",        32'(word_count), 0);
        chk("empty_we_count",  32'(n_we),      32'(we0));

        // Largest image: addresses 0..4095 with no wrap.
        do_reset();
        we0 = n_we;
        for (int i = 0; i < 4096; i++) begin
            img[i] = 16'(i * 7) ^ 16'hC3A5;
        end
        send_image(4096);
        wait_after_last();
        chk("max_done",     32'(done),       1);
        chk("max_error",    32'(error),      0);
        chk("max_wc",       32'(word_count), 4096);
        chk("max_addr",     32'(imem_addr),  0);
        chk("max_sb_empty", 32'(exp_q.size()), 0);
        chk("max_we_count", 32'(n_we),       32'(we0 + 4096));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
